// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-tx state encoding, command bytes, frame geometry.
// Optional ACK state is present only when PS2_TX_ACK_EN is defined.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
`ifdef PS2_TX_ACK_EN
    ACK,
`endif
    FINISH
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Purpose: 2-flop synchroniser for the PS/2 clock and data lines plus clock falling-edge detect.
// Latency: clk_fall and data_sync appear 2 cycles after the line changes; edge pulse lasts 1 cycle.
// Backpressure: none; free-running sampler.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic clk_sync;
  logic clk_prev;
  logic data_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b0;
      clk_sync  <= 1'b0;
      clk_prev  <= 1'b0;
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, optional ACK via PS2_TX_ACK_EN).
// Latency: INHIBIT_CYCLES + one REQ cycle + device-clocked frame; done/err are single-cycle pulses.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is dropped, not queued.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t state_q, state_d;

  logic [INH_W-1:0]        inh_cnt_q;
  logic [TO_W-1:0]         to_cnt_q;
  logic [3:0]              bit_idx_q;
  logic [FRAME_BITS-2:0]   frame_q;      // {stop, parity, d7..d0}
  logic                    data_low_q;
  logic                    stop_sent_q;
  logic                    data_sync;
  logic                    clk_fall;
  logic                    timed;
  logic                    timeout;
  logic                    inh_last;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

`ifndef PS2_TX_ACK_EN
  logic unused_data_sync;
  assign unused_data_sync = data_sync;
`endif

  always_comb begin
    timed = (state_q == REQ) || (state_q == SEND);
`ifdef PS2_TX_ACK_EN
    if (state_q == ACK) timed = 1'b1;
`endif
  end

  // A falling edge restarts the window, so it takes precedence over expiry.
  assign timeout  = timed && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) && !clk_fall;
  assign inh_last = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) state_d = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_last) state_d = REQ;
      end
      REQ: begin
        ps2_data_oe = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        ps2_data_oe = data_low_q;
        if (clk_fall && stop_sent_q) begin
`ifdef PS2_TX_ACK_EN
          state_d = ACK;
`else
          state_d = FINISH;
`endif
        end
      end
`ifdef PS2_TX_ACK_EN
      ACK: begin
        if (clk_fall) begin
          if (data_sync) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FINISH;
          end
        end
      end
`endif
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      err         = 1'b1;
      state_d     = IDLE;
    end

    // Lines are released and pulses suppressed in the reset cycle itself.
    if (rst) begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '0;
      data_low_q  <= 1'b0;
      stop_sent_q <= 1'b0;
    end else begin
      if (state_q == IDLE && tx_valid) begin
        frame_q   <= {1'b1, odd_parity(tx_data), tx_data};
        inh_cnt_q <= '0;
      end

      if (state_q == INHIBIT) begin
        inh_cnt_q   <= inh_cnt_q + INH_W'(1);
        bit_idx_q   <= '0;
        stop_sent_q <= 1'b0;
        data_low_q  <= 1'b1;
      end

      if (state_q == INHIBIT || clk_fall) to_cnt_q <= '0;
      else if (timed)                     to_cnt_q <= to_cnt_q + TO_W'(1);

      if (state_q == SEND && clk_fall && !stop_sent_q) begin
        data_low_q <= ~frame_q[bit_idx_q];
        if (bit_idx_q == 4'd9) stop_sent_q <= 1'b1;
        else                   bit_idx_q   <= bit_idx_q + 4'd1;
      end
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, scoreboard of expected frames/outcomes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, done, err, busy;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_i  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err         (err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit        is_err;
    bit [10:0] frame;
  } exp_t;

  exp_t      exp_q[$];
  exp_t      mon_e;
  int        checks = 0;
  int        errors = 0;
  bit [10:0] dev_frame = '0;
  int        last_fall_cyc = 0;
  int        err_cyc = -1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Expected line levels: start 0, data LSB first, odd parity, stop 1.
  function automatic bit [10:0] model_frame(input bit [7:0] b);
    bit [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      check("done_err_exclusive", int'(done & err), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse got done=%0b err=%0b want no pulse", done, err);
      end else begin
        mon_e = exp_q.pop_front();
        check("outcome_err", int'(err), int'(mon_e.is_err));
        if (done && !mon_e.is_err) check("frame_bits", int'(dev_frame), int'(mon_e.frame));
      end
      if (err) err_cyc = cyc;
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 600 && !tx_ready; i++) @(negedge clk);
    check(name, int'(tx_ready), 1);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit push, input bit is_err);
    exp_t e;
    wait_ready("ready_before_send");
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    if (push) begin
      e.is_err = is_err;
      e.frame  = model_frame(b);
      exp_q.push_back(e);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device: wait for request-to-send, then generate n_falls clock pulses,
  // sampling data on each rising edge; optionally hold data low for the ack.
  task automatic dev_run(input int n_falls, input bit ack_low, output int inh_seen);
    bit got_req;
    inh_seen = 0;
    got_req  = 1'b0;
    for (int w = 0; w < INH + 200; w++) begin
      if (ps2_clk_oe) inh_seen++;
      if (ps2_clk_i && !ps2_data_i) begin
        got_req = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("request_seen", int'(got_req), 1);
    if (got_req) begin
      dev_frame[0] = ps2_data_i;
      for (int k = 1; k <= n_falls; k++) begin
        repeat (HALF) @(negedge clk);
        dev_clk       = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (k <= 10) dev_frame[k] = ps2_data_i;
        if (k == 10 && ack_low) dev_data = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic full_frame(input bit [7:0] b);
    int inh;
    send_byte(b, 1'b1, 1'b0);
    dev_run(12, 1'b1, inh);
    check("inhibit_cycles", inh, INH);
    wait_ready("ready_after_done");
  endtask

  initial begin
    int        inh;
    bit [7:0]  b;
    bit        seen_oe;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    full_frame(CMD_SET_LED);
    full_frame(8'h01);
    full_frame(CMD_RESET);
    for (int n = 0; n < 4; n++) full_frame(8'($urandom));

    // Request while busy must be dropped; frame keeps the original byte.
    b = 8'($urandom_range(0, 254));
    if (b == 8'h55) b = 8'hAA;
    send_byte(b, 1'b1, 1'b0);
    fork
      dev_run(12, 1'b1, inh);
      begin
        repeat (60) @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_ready("ready_after_ignored");
    seen_oe = 1'b0;
    repeat (INH + 10) begin
      @(negedge clk);
      if (ps2_clk_oe || ps2_data_oe) seen_oe = 1'b1;
    end
    check("no_queued_frame", int'(seen_oe), 0);

    // Device stalls after D4: timeout error.
    err_cyc = -1;
    send_byte(8'($urandom), 1'b1, 1'b1);
    dev_run(5, 1'b0, inh);
    for (int i = 0; i < TO + 100 && err_cyc < 0; i++) @(negedge clk);
    check("timeout_latency", err_cyc - last_fall_cyc, TO + 2);
    @(negedge clk);
    check("timeout_clk_oe", int'(ps2_clk_oe), 0);
    check("timeout_data_oe", int'(ps2_data_oe), 0);
    wait_ready("ready_after_timeout");

`ifdef PS2_TX_ACK_EN
    send_byte(8'($urandom), 1'b1, 1'b1);
    dev_run(12, 1'b0, inh);
    wait_ready("ready_after_nack");
`endif

    // Reset while bit 6 is on the line.
    send_byte(8'($urandom), 1'b0, 1'b0);
    dev_run(7, 1'b0, inh);
    check("busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_same_cycle_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_same_cycle_data_oe", int'(ps2_data_oe), 0);
    check("rst_same_cycle_done", int'(done), 0);
    check("rst_same_cycle_err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tx_ready", int'(tx_ready), 1);
    check("rst_mid_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_mid_data_oe", int'(ps2_data_oe), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_err", int'(err), 0);

    full_frame(CMD_ECHO);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
